magnitude_peak_finder: RTL
==========================

Name: magnitude_peak_finder

Overview:
- Sits directly downstream of the magnitude stage: consumes one 13-bit spectral magnitude per accepted beat, one FFT frame at a time.
- Scans a configurable bin window for the largest magnitude and reports the winning bin index and value once per frame.
- The downstream note-mapping logic reads the result through a valid/ready handshake.
- Scanning of the next frame continues while a result is waiting to be consumed.

Parameters:
- FFT_LEN, 8192, bins per frame; power of two.
- MAG_W, 13, magnitude width; matches the magnitude stage result.
- BIN_W, 13, bin index width; log2(FFT_LEN).
- BIN_LO, 1, first bin considered; excludes DC.
- BIN_HI, 4095, last bin considered inclusive; upper half is a mirror and is ignored.
- THRESH, 64, minimum peak magnitude for peak_found=1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- mag_in  in  MAG_W  magnitude of the current bin.
- mag_valid  in  1  mag_in, mag_sop and mag_eop are valid this cycle.
- mag_sop  in  1  first bin (bin 0) of a frame.
- mag_eop  in  1  last bin of a frame.
- peak_bin  out  BIN_W  bin index of the reported peak.
- peak_mag  out  MAG_W  magnitude of the reported peak.
- peak_found  out  1  peak_mag >= THRESH.
- peak_valid  out  1  result registers hold an unconsumed result.
- peak_ready  in  1  consumer accepts the result.
- frame_err  out  1  one-cycle pulse: malformed frame discarded.
- overrun  out  1  one-cycle pulse: an unconsumed result was overwritten.

Behaviour:
- Reset (asynchronous, reset_n low):
  - All outputs 0, state IDLE.
  - Scan registers and bin counter cleared.
  - An in-flight frame is lost; no result is produced for it.
- Beat definition: an input beat occurs when mag_valid=1. There is no backpressure on the input; every valid beat is taken.
- State machine, scan side:
  - IDLE: beats without mag_sop are ignored. A beat with mag_sop goes to SCAN, sets bin_cnt=1 and processes the beat as bin 0.
  - SCAN: each beat is processed as bin bin_cnt, then bin_cnt increments.
  - A beat with mag_sop inside SCAN means the old frame is aborted: frame_err pulses and a new frame starts at bin 0 with scan registers reinitialised.
  - A beat with mag_eop goes to IDLE.
    - If the eop beat's bin index equals FFT_LEN-1, the frame is complete.
    - Otherwise frame_err pulses and no result is produced.
  - If bin_cnt would pass FFT_LEN-1 without mag_eop, frame_err pulses, the frame is discarded and the state goes to IDLE.
  - sop and eop on the same beat count as a frame of length 1, which is an error unless FFT_LEN=1.
- Peak tracking:
  - Only bins with BIN_LO <= idx <= BIN_HI are candidates.
  - The running maximum is initialised to 0 with best_bin=BIN_LO at frame start.
  - Update uses strict greater-than, so on ties the lowest bin wins.
  - An all-zero window yields bin BIN_LO, magnitude 0.
- Result commit (the cycle after a complete eop beat):
  - best_bin, best_mag and (best_mag >= THRESH) are copied to peak_bin, peak_mag and peak_found.
  - peak_valid=1.
  - Latency from the eop beat to peak_valid is 1 clk.
- Output handshake:
  - Result outputs stay stable while peak_valid=1 and peak_ready=0.
  - On a cycle with peak_valid=1 and peak_ready=1, the result is consumed and peak_valid drops next cycle unless a commit occurs that same cycle.
  - Commit while peak_valid=1 and peak_ready=0: new result overwrites and overrun pulses.
  - Commit in the same cycle as a consume: the new result loads, peak_valid stays 1 and overrun does not pulse.
- Widths: comparisons are unsigned MAG_W bits. bin_cnt is BIN_W+1 bits so that overflow can be detected.

Decomposition:
- Shared package (guitar_hero_pkg) holds:
  - MAG_W, BIN_W and FFT_LEN defaults.
  - The scan-state enum {IDLE, SCAN}.
  - A peak_result_t struct {bin, mag, found}.
- One natural sub-module: peak_result_reg, the valid/ready holding register with overwrite and overrun logic.
- The scan FSM and comparator stay in the top module.

Test Plan:
Bench uses FFT_LEN=16, BIN_W=4, BIN_LO=1, BIN_HI=7, THRESH=64.
1. Single peak. Frame with bins 0..15 all =10 except bin 5=300 and bin 12=900, peak_ready=1 -> peak_valid 1 clk after eop; peak_bin=5, peak_mag=300, peak_found=1. Bin 12 is ignored as outside the window; bin 0 is ignored as DC.
2. Tie and threshold. Bins 3 and 6 both =50, all others 0 -> peak_bin=3, peak_mag=50, peak_found=0. All bins 0 -> peak_bin=1, peak_mag=0, peak_found=0.
3. Backpressure and overrun. peak_ready=0 across two good frames (peaks 200@bin2, then 400@bin7) -> outputs hold bin2/200 until the second commit; overrun pulses once; outputs become bin7/400. Raising peak_ready then drops peak_valid next cycle.
4. Malformed frames.
   - mag_eop at bin 9 -> frame_err pulse, peak_valid stays 0.
   - mag_sop at bin 6 followed by a full 16-bin frame -> frame_err pulse once, then a correct result for the new frame.
5. Gaps and IDLE filtering. Valid beats arriving with random mag_valid=0 gaps give the same result as gap-free input. Beats without sop while IDLE produce no effect.
6. Reset mid-frame. Drop reset_n at bin 8 -> all outputs 0 immediately. After release, a full frame yields the correct result, with no trace of the earlier frame.

Source files
------------

// File: rtl/guitar_hero_pkg.sv
// Shared types and default sizes for the spectral peak-finding stage.
package guitar_hero_pkg;

    // Default frame geometry, matching the magnitude stage output.
    localparam int FFT_LEN_DEF = 8192;
    localparam int MAG_W_DEF   = 13;
    localparam int BIN_W_DEF   = 13;

    // Scan-side state: waiting for a start-of-frame, or walking through bins.
    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_t;

    // One reported peak at the default widths, as seen by the note mapper.
    typedef struct packed {
        logic [BIN_W_DEF-1:0] bin;
        logic [MAG_W_DEF-1:0] mag;
        logic                 found;
    } peak_result_t;

endpackage

// File: rtl/magnitude_peak_finder_result_reg.sv
// Holding register for the reported peak. Presents the result with a
// valid/ready handshake and lets a fresh commit overwrite an unconsumed one.
//
// Handshake: a result transfers on any cycle where valid and ready are both
// high; while valid is high and ready is low the result fields do not change
// unless a new commit overwrites them, in which case overrun pulses.
module peak_result_reg #(
    parameter int MAG_W = 13,
    parameter int BIN_W = 13
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [BIN_W-1:0] load_bin,
    input  logic [MAG_W-1:0] load_mag,
    input  logic             load_found,
    input  logic             ready,
    output logic             valid,
    output logic [BIN_W-1:0] bin,
    output logic [MAG_W-1:0] mag,
    output logic             found,
    output logic             overrun
);

    // Load on commit, drop valid on consume, flag a commit that lands on an
    // unconsumed result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid   <= 1'b0;
            bin     <= '0;
            mag     <= '0;
            found   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (load) begin
                valid   <= 1'b1;
                bin     <= load_bin;
                mag     <= load_mag;
                found   <= load_found;
                overrun <= valid && !ready;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/magnitude_peak_finder.sv
// Frame-by-frame peak search over a bin window of the magnitude spectrum.
// Tracks the largest in-window magnitude while a frame streams in, then
// commits bin/magnitude/threshold flag into the output holding register.
module magnitude_peak_finder
    import guitar_hero_pkg::*;
#(
    parameter int FFT_LEN = FFT_LEN_DEF,
    parameter int MAG_W   = MAG_W_DEF,
    parameter int BIN_W   = BIN_W_DEF,
    parameter int BIN_LO  = 1,
    parameter int BIN_HI  = 4095,
    parameter int THRESH  = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [MAG_W-1:0] mag_in,
    input  logic             mag_valid,
    input  logic             mag_sop,
    input  logic             mag_eop,
    output logic [BIN_W-1:0] peak_bin,
    output logic [MAG_W-1:0] peak_mag,
    output logic             peak_found,
    output logic             peak_valid,
    input  logic             peak_ready,
    output logic             frame_err,
    output logic             overrun,
    output scan_state_t      scan_state
);

    localparam logic [BIN_W-1:0] LO   = BIN_W'(BIN_LO);
    localparam logic [BIN_W-1:0] HI   = BIN_W'(BIN_HI);
    localparam logic [BIN_W-1:0] LAST = BIN_W'(FFT_LEN - 1);
    localparam logic [MAG_W-1:0] TH   = MAG_W'(THRESH);

    scan_state_t      state, state_next;
    logic [BIN_W:0]   bin_cnt;     // extra MSB marks "ran past the last bin"
    logic [BIN_W-1:0] best_bin;
    logic [MAG_W-1:0] best_mag;

    logic             beat;
    logic             ovf;
    logic [BIN_W-1:0] idx;
    logic [BIN_W:0]   cnt_inc;
    logic [BIN_W-1:0] base_bin, nxt_bin;
    logic [MAG_W-1:0] base_mag, nxt_mag;
    logic             take;
    logic             err_next;
    logic             commit;
    logic             commit_found;

    // Per-beat datapath: bin index, window test and running-maximum update.
    always_comb begin
        beat     = mag_valid && (state == SCAN || mag_sop);
        ovf      = (state == SCAN) && !mag_sop && bin_cnt[BIN_W];
        idx      = mag_sop ? '0 : bin_cnt[BIN_W-1:0];
        cnt_inc  = {1'b0, idx} + {{BIN_W{1'b0}}, 1'b1};
        base_bin = mag_sop ? LO : best_bin;
        base_mag = mag_sop ? '0 : best_mag;
        take     = (idx >= LO) && (idx <= HI) && (mag_in > base_mag);
        nxt_bin  = take ? idx : base_bin;
        nxt_mag  = take ? mag_in : base_mag;
    end

    // Scan FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Scan FSM next state: any accepted beat keeps scanning unless it ends
    // the frame (eop) or arrives after the frame has already run out of bins.
    always_comb begin
        state_next = state;
        if (beat) begin
            if (mag_eop || ovf) state_next = IDLE;
            else                state_next = SCAN;
        end
    end

    // Scan FSM outputs: malformed-frame detection and result commit.
    always_comb begin
        err_next     = beat && (ovf ||
                                (state == SCAN && mag_sop) ||
                                (mag_eop && idx != LAST));
        commit       = beat && mag_eop && !ovf && (idx == LAST);
        commit_found = nxt_mag >= TH;
    end

    // Scan registers and the registered frame-error pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bin_cnt   <= '0;
            best_bin  <= '0;
            best_mag  <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= err_next;
            if (beat) begin
                bin_cnt  <= cnt_inc;
                best_bin <= nxt_bin;
                best_mag <= nxt_mag;
            end
        end
    end

    assign scan_state = state;

    peak_result_reg #(
        .MAG_W (MAG_W),
        .BIN_W (BIN_W)
    ) u_result (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (commit),
        .load_bin   (nxt_bin),
        .load_mag   (nxt_mag),
        .load_found (commit_found),
        .ready      (peak_ready),
        .valid      (peak_valid),
        .bin        (peak_bin),
        .mag        (peak_mag),
        .found      (peak_found),
        .overrun    (overrun)
    );

endmodule
